// File: rtl/core_pkg.sv
// Shared OBI definitions for the memory responder.
//   OBI_DATA_W    : data width of the obi_resp_t layout.
//   OBI_ATOP_NONE : the only atomic opcode the responder accepts.
//   obi_resp_t    : one queued response, {rdata, err}.
// The responder packs its queue entries in this same {rdata, err} order
// for any WIDTH. obi_resp_t gives that layout at the default 32-bit width.
package core_pkg;

    localparam int         OBI_DATA_W    = 32;
    localparam logic [5:0] OBI_ATOP_NONE = 6'h00;

    typedef struct packed {
        logic [OBI_DATA_W-1:0] rdata;
        logic                  err;
    } obi_resp_t;

endpackage

// File: rtl/obi_resp_fifo.sv
// In-order response queue for the OBI memory responder.
//   clk, rst_n : clock and asynchronous active-low reset. Reset clears the
//                pointers and the count, not the storage.
//   i_push     : enqueue i_data. Ignored when full.
//   i_pop      : dequeue the head. Ignored when empty.
//   o_data     : head entry. Only meaningful when o_empty is low.
//   o_full     : high when the queue holds DEPTH entries.
//   o_empty    : high when the queue holds no entries.
//   o_count    : number of entries held.
module obi_resp_fifo
    import core_pkg::*;
#(
    parameter int WIDTH = OBI_DATA_W + 1,
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       i_push,
    input  logic [WIDTH-1:0]           i_data,
    input  logic                       i_pop,
    output logic [WIDTH-1:0]           o_data,
    output logic                       o_full,
    output logic                       o_empty,
    output logic [$clog2(DEPTH+1)-1:0] o_count
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] r_data [DEPTH];
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             w_push;
    logic             w_pop;

    // Pointers wrap at DEPTH-1, so DEPTH need not be a power of two.
    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign o_full  = (r_count == CW'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_count = r_count;
    assign o_data  = r_data[r_rd_ptr];
    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= next_ptr(r_wr_ptr);
            if (w_pop)  r_rd_ptr <= next_ptr(r_rd_ptr);
            // A push and a pop in the same cycle leave the count unchanged.
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // The storage has no reset. Entries are only read once they have been pushed.
    always_ff @(posedge clk) begin
        if (w_push) r_data[r_wr_ptr] <= i_data;
    end

endmodule

// File: rtl/obi_mem_responder.sv
// OBI memory responder: a word-addressed RAM behind an OBI port.
// Responses are queued and returned in acceptance order.
//   clk, rst_n                : clock and asynchronous active-low reset.
//   obi_req_i / obi_gnt_o     : address phase.
//   obi_addr_i                : byte address; bits [1:0] are ignored.
//   obi_we_i                  : 1 = write, 0 = read.
//   obi_be_i                  : byte enables, used for writes only.
//   obi_wdata_i               : write data.
//   obi_atop_i                : atomic opcode; any non-zero value is an error.
//   obi_rvalid_o/obi_rready_i : response phase.
//   obi_rdata_o, obi_err_o    : response payload. Both read 0 when no response is valid.
// Handshakes: the address phase completes on a rising edge where
// req && gnt. A response is consumed on a rising edge where
// rvalid && rready. While rready is low, rvalid/rdata/err stay stable.
module obi_mem_responder
    import core_pkg::*;
#(
    parameter int WIDTH           = 32,
    parameter int DEPTH           = 1024,
    parameter int MAX_OUTSTANDING = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             obi_req_i,
    output logic             obi_gnt_o,
    input  logic [WIDTH-1:0] obi_addr_i,
    input  logic             obi_we_i,
    input  logic [3:0]       obi_be_i,
    input  logic [WIDTH-1:0] obi_wdata_i,
    input  logic [5:0]       obi_atop_i,
    output logic             obi_rvalid_o,
    input  logic             obi_rready_i,
    output logic [WIDTH-1:0] obi_rdata_o,
    output logic             obi_err_o
);

    localparam int IDX_W = WIDTH - 2;
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int NB    = (WIDTH / 8 < 4) ? WIDTH / 8 : 4;
    localparam int RW    = WIDTH + 1;
    localparam int CW    = $clog2(MAX_OUTSTANDING + 1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [IDX_W-1:0] w_index;
    logic [AW-1:0]    w_waddr;
    logic             w_oob;
    logic             w_err;
    logic             w_accept;
    logic             w_pop;
    logic             w_full;
    logic             w_empty;
    logic [WIDTH-1:0] w_rd_data;
    logic [RW-1:0]    w_push_data;
    logic [RW-1:0]    w_head;
    logic [CW-1:0]    w_count;
    logic             w_unused;

    assign w_index = obi_addr_i[WIDTH-1:2];
    assign w_waddr = w_index[AW-1:0];
    // Compare the full index so that aliases above DEPTH are rejected rather than wrapped.
    assign w_oob   = ({{(64-IDX_W){1'b0}}, w_index} >= 64'(DEPTH));
    assign w_err   = w_oob || (obi_atop_i != OBI_ATOP_NONE);

    // Grant depends only on the current count. A pop in the same cycle does
    // not open a slot until the next cycle. rst_n is in the term so that the
    // grant drops as soon as reset asserts.
    assign obi_gnt_o = rst_n && obi_req_i && !w_full;
    assign w_accept  = obi_req_i && obi_gnt_o;
    assign w_pop     = obi_rvalid_o && obi_rready_i;

    // Read data is captured at acceptance, so a write on an earlier edge is visible.
    assign w_rd_data   = (obi_we_i || w_err) ? '0 : r_mem[w_waddr];
    assign w_push_data = {w_rd_data, w_err};

    // The memory has no reset. Completed writes survive a reset.
    always_ff @(posedge clk) begin
        if (w_accept && obi_we_i && !w_err) begin
            for (int k = 0; k < NB; k++) begin
                if (obi_be_i[k]) r_mem[w_waddr][8*k +: 8] <= obi_wdata_i[8*k +: 8];
            end
        end
    end

    obi_resp_fifo #(
        .WIDTH (RW),
        .DEPTH (MAX_OUTSTANDING)
    ) u_resp_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_accept),
        .i_data  (w_push_data),
        .i_pop   (w_pop),
        .o_data  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    assign obi_rvalid_o = !w_empty;
    assign obi_rdata_o  = w_empty ? '0 : w_head[RW-1:1];
    assign obi_err_o    = !w_empty && w_head[0];

    assign w_unused = ^{obi_addr_i[1:0], w_count};

endmodule

// File: tb/tb_obi_mem_responder.sv
module tb_obi_mem_responder;
  import core_pkg::*;

  localparam int DEPTH = 64;
  localparam int MAXO  = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        obi_req_i;
  logic        obi_gnt_o;
  logic [31:0] obi_addr_i;
  logic        obi_we_i;
  logic [3:0]  obi_be_i;
  logic [31:0] obi_wdata_i;
  logic [5:0]  obi_atop_i;
  logic        obi_rvalid_o;
  logic        obi_rready_i;
  logic [31:0] obi_rdata_o;
  logic        obi_err_o;

  int checks = 0;
  int errors = 0;

  obi_resp_t   exp_q[$];
  obi_resp_t   got_q[$];
  logic [31:0] model_mem [DEPTH];

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [5:0]  atop;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  localparam int NVEC = 14;
  vec_t vecs [NVEC];

  obi_mem_responder #(
    .WIDTH           (32),
    .DEPTH           (DEPTH),
    .MAX_OUTSTANDING (MAXO)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .obi_req_i    (obi_req_i),
    .obi_gnt_o    (obi_gnt_o),
    .obi_addr_i   (obi_addr_i),
    .obi_we_i     (obi_we_i),
    .obi_be_i     (obi_be_i),
    .obi_wdata_i  (obi_wdata_i),
    .obi_atop_i   (obi_atop_i),
    .obi_rvalid_o (obi_rvalid_o),
    .obi_rready_i (obi_rready_i),
    .obi_rdata_o  (obi_rdata_o),
    .obi_err_o    (obi_err_o)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h required %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s: got timeout required response at %0t", name, $time);
  endtask

  // reference model and scoreboard: samples on the falling edge
  obi_resp_t   m_rsp;
  int unsigned m_idx;
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      chk("rst_rvalid", 32'(obi_rvalid_o), 32'd0);
      chk("rst_gnt", 32'(obi_gnt_o), 32'd0);
      chk("rst_rdata", obi_rdata_o, 32'd0);
      chk("rst_err", 32'(obi_err_o), 32'd0);
    end else begin
      chk("gnt", 32'(obi_gnt_o), 32'(obi_req_i && (exp_q.size() < MAXO)));
      chk("rvalid", 32'(obi_rvalid_o), 32'(exp_q.size() != 0));
      if (exp_q.size() != 0) begin
        chk("rdata", obi_rdata_o, exp_q[0].rdata);
        chk("err", 32'(obi_err_o), 32'(exp_q[0].err));
      end else begin
        chk("idle_rdata", obi_rdata_o, 32'd0);
        chk("idle_err", 32'(obi_err_o), 32'd0);
      end
      if (obi_rvalid_o && obi_rready_i && exp_q.size() != 0) begin
        got_q.push_back('{rdata: obi_rdata_o, err: obi_err_o});
        void'(exp_q.pop_front());
      end
      if (obi_req_i && obi_gnt_o) begin
        m_idx = obi_addr_i >> 2;
        m_rsp = '{rdata: 32'd0, err: 1'b0};
        if (m_idx >= DEPTH || obi_atop_i != 6'd0) begin
          m_rsp.err = 1'b1;
        end else if (obi_we_i) begin
          for (int k = 0; k < 4; k++)
            if (obi_be_i[k]) model_mem[m_idx][8*k +: 8] = obi_wdata_i[8*k +: 8];
        end else begin
          m_rsp.rdata = model_mem[m_idx];
        end
        exp_q.push_back(m_rsp);
      end
    end
  end

  // driver tasks (called just after a rising edge)
  task automatic set_bus(input logic we, input logic [31:0] addr, input logic [3:0] be,
                         input logic [31:0] wdata, input logic [5:0] atop);
    obi_req_i   = 1'b1;
    obi_we_i    = we;
    obi_addr_i  = addr;
    obi_be_i    = be;
    obi_wdata_i = wdata;
    obi_atop_i  = atop;
  endtask

  task automatic idle_bus();
    obi_req_i   = 1'b0;
    obi_we_i    = 1'b0;
    obi_addr_i  = 32'd0;
    obi_be_i    = 4'd0;
    obi_wdata_i = 32'd0;
    obi_atop_i  = 6'd0;
  endtask

  task automatic drive_txn(input logic we, input logic [31:0] addr, input logic [3:0] be,
                           input logic [31:0] wdata, input logic [5:0] atop);
    int waits;
    waits = 0;
    set_bus(we, addr, be, wdata, atop);
    forever begin
      @(negedge clk);
      if (obi_gnt_o) begin
        @(posedge clk); #1;
        break;
      end
      @(posedge clk); #1;
      waits++;
      if (waits > 20) begin
        fail_now("gnt_wait");
        break;
      end
    end
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    idle_bus();
    obi_rready_i = 1'b1;
    while (exp_q.size() != 0 && n < 30) begin
      @(posedge clk); #1;
      n++;
    end
    if (exp_q.size() != 0) fail_now(name);
  endtask

  initial begin
    int n;
    rst_n = 1'b0;
    obi_rready_i = 1'b1;
    idle_bus();
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_rvalid", 32'(obi_rvalid_o), 32'd0);
    chk("post_rst_gnt_idle", 32'(obi_gnt_o), 32'd0);
    @(posedge clk); #1;

    // fill every word so the model never holds unknown data
    for (int i = 0; i < DEPTH; i++) drive_txn(1'b1, 32'(i * 4), 4'hF, $urandom, 6'd0);
    drain("fill_drain");

    // table-driven directed vectors, issued back to back with rready=1
    vecs[0]  = '{1'b1, 32'h10,  4'hF, 32'hDEADBEEF, 6'h00, 32'h0,        1'b0};
    vecs[1]  = '{1'b0, 32'h10,  4'hF, 32'h0,        6'h00, 32'hDEADBEEF, 1'b0};
    vecs[2]  = '{1'b1, 32'h20,  4'hF, 32'h11223344, 6'h00, 32'h0,        1'b0};
    vecs[3]  = '{1'b1, 32'h20,  4'h5, 32'hAABBCCDD, 6'h00, 32'h0,        1'b0};
    vecs[4]  = '{1'b0, 32'h20,  4'hF, 32'h0,        6'h00, 32'h11BB33DD, 1'b0};
    vecs[5]  = '{1'b0, 32'h100, 4'hF, 32'h0,        6'h00, 32'h0,        1'b1};
    vecs[6]  = '{1'b1, 32'h20,  4'hF, 32'hFFFFFFFF, 6'h21, 32'h0,        1'b1};
    vecs[7]  = '{1'b0, 32'h20,  4'hF, 32'h0,        6'h00, 32'h11BB33DD, 1'b0};
    vecs[8]  = '{1'b1, 32'h40,  4'hF, 32'h5A5A5A5A, 6'h00, 32'h0,        1'b0};
    vecs[9]  = '{1'b0, 32'h40,  4'hF, 32'h0,        6'h00, 32'h5A5A5A5A, 1'b0};
    vecs[10] = '{1'b0, 32'h13,  4'hF, 32'h0,        6'h00, 32'hDEADBEEF, 1'b0};
    vecs[11] = '{1'b1, 32'hFC,  4'hF, 32'hCAFEF00D, 6'h00, 32'h0,        1'b0};
    vecs[12] = '{1'b0, 32'hFF,  4'h0, 32'h0,        6'h00, 32'hCAFEF00D, 1'b0};
    vecs[13] = '{1'b1, 32'h104, 4'hF, 32'h12345678, 6'h00, 32'h0,        1'b1};
    got_q.delete();
    for (int i = 0; i < NVEC; i++)
      drive_txn(vecs[i].we, vecs[i].addr, vecs[i].be, vecs[i].wdata, vecs[i].atop);
    idle_bus();
    n = 0;
    while (got_q.size() < NVEC && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    for (int i = 0; i < NVEC; i++) begin
      if (i < got_q.size()) begin
        chk($sformatf("vec%0d_rdata", i), got_q[i].rdata, vecs[i].exp_rdata);
        chk($sformatf("vec%0d_err", i), 32'(got_q[i].err), 32'(vecs[i].exp_err));
      end else begin
        fail_now($sformatf("vec%0d_missing", i));
      end
    end

    // one-cycle response latency
    set_bus(1'b0, 32'h10, 4'hF, 32'h0, 6'h00);
    @(negedge clk);
    chk("lat_gnt", 32'(obi_gnt_o), 32'd1);
    chk("lat_rvalid_early", 32'(obi_rvalid_o), 32'd0);
    @(posedge clk); #1;
    idle_bus();
    @(negedge clk);
    chk("lat_rvalid", 32'(obi_rvalid_o), 32'd1);
    chk("lat_rdata", obi_rdata_o, 32'hDEADBEEF);
    @(posedge clk); #1;

    // backpressure: third read held until a slot frees
    obi_rready_i = 1'b0;
    set_bus(1'b0, 32'h10, 4'hF, 32'h0, 6'h00);
    @(negedge clk); chk("bp_gnt0", 32'(obi_gnt_o), 32'd1);
    @(posedge clk); #1;
    set_bus(1'b0, 32'h20, 4'hF, 32'h0, 6'h00);
    @(negedge clk); chk("bp_gnt1", 32'(obi_gnt_o), 32'd1);
    @(posedge clk); #1;
    set_bus(1'b0, 32'h40, 4'hF, 32'h0, 6'h00);
    @(negedge clk); chk("bp_gnt2_held", 32'(obi_gnt_o), 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("bp_gnt2_still", 32'(obi_gnt_o), 32'd0);
    chk("bp_hold_rdata", obi_rdata_o, 32'hDEADBEEF);
    @(posedge clk); #1;
    obi_rready_i = 1'b1;
    @(negedge clk);
    chk("bp_pop_no_free", 32'(obi_gnt_o), 32'd0);
    chk("bp_first", obi_rdata_o, 32'hDEADBEEF);
    @(posedge clk); #1;
    @(negedge clk);
    chk("bp_gnt2_now", 32'(obi_gnt_o), 32'd1);
    chk("bp_second", obi_rdata_o, 32'h11BB33DD);
    @(posedge clk); #1;
    idle_bus();
    @(negedge clk);
    chk("bp_third", obi_rdata_o, 32'h5A5A5A5A);
    @(posedge clk); #1;
    drain("bp_drain");

    // reset with a full queue; memory survives
    obi_rready_i = 1'b0;
    drive_txn(1'b0, 32'h10, 4'hF, 32'h0, 6'h00);
    drive_txn(1'b0, 32'h20, 4'hF, 32'h0, 6'h00);
    set_bus(1'b0, 32'h40, 4'hF, 32'h0, 6'h00);
    @(negedge clk);
    chk("full_gnt", 32'(obi_gnt_o), 32'd0);
    chk("full_rvalid", 32'(obi_rvalid_o), 32'd1);
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    chk("async_rst_rvalid", 32'(obi_rvalid_o), 32'd0);
    chk("async_rst_rdata", obi_rdata_o, 32'd0);
    chk("async_rst_gnt", 32'(obi_gnt_o), 32'd0);
    @(negedge clk);
    @(posedge clk); #1;
    rst_n = 1'b1;
    obi_rready_i = 1'b1;
    drive_txn(1'b0, 32'h40, 4'hF, 32'h0, 6'h00);
    idle_bus();
    n = 0;
    while (!obi_rvalid_o && n < 10) begin
      @(negedge clk);
      n++;
    end
    if (obi_rvalid_o) chk("post_rst_read", obi_rdata_o, 32'h5A5A5A5A);
    else fail_now("post_rst_read");
    @(posedge clk); #1;
    drain("rst_drain");

    // randomized traffic against the model
    for (int c = 0; c < 600; c++) begin
      obi_req_i    = ($urandom_range(0, 9) < 7);
      obi_we_i     = 1'($urandom_range(0, 1));
      obi_addr_i   = ($urandom_range(0, 9) == 0) ? $urandom_range(DEPTH * 4, DEPTH * 4 + 64)
                                                 : $urandom_range(0, DEPTH * 4 - 1);
      obi_be_i     = 4'($urandom_range(0, 15));
      obi_wdata_i  = $urandom;
      obi_atop_i   = ($urandom_range(0, 9) == 0) ? 6'($urandom_range(1, 63)) : 6'd0;
      obi_rready_i = ($urandom_range(0, 9) < 6);
      @(posedge clk); #1;
    end
    drain("rand_drain");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
